// File: rtl/frame_read_sequencer.sv
// -----------------------------------------------------------------------------
// frame_read_sequencer
//
// Read-side controller for the frame memory feeding the image processor.
// Walks the frame in raster order, presenting one read address per RUN
// cycle. Optional idle gaps follow every line, issue can be held at line
// boundaries, and frames run single-shot or back to back. A tag pipeline
// as deep as the memory read latency carries valid/sof/eol/eof/col/row
// alongside each address, so the tags line up with the returned read data.
//
// Ports
//   clk_i          clock (clk_25_vga domain)
//   reset_i        synchronous, active-high reset
//   start_i        pulse; begins a frame when idle
//   continuous_i   sampled at frame end; 1 = start the next frame automatically
//   stop_i         pulse; finish the current frame, then go idle (sticky)
//   pause_i        level; sampled at line end / gap expiry; holds issue
//   rdaddress_o    read address to stream_mif
//   busy_o         high in every state except IDLE
//   pix_valid_o    read data valid this cycle
//   pix_sof_o      first pixel of frame (with pix_valid_o)
//   pix_eol_o      last pixel of line (with pix_valid_o)
//   pix_eof_o      last pixel of frame (with pix_valid_o)
//   pix_col_o      column of the current valid pixel
//   pix_row_o      row of the current valid pixel
//   frame_done_o   one-cycle pulse coincident with the pix_eof_o beat
// -----------------------------------------------------------------------------
module frame_read_sequencer #(
    parameter int H_PIXELS   = 320,
    parameter int V_LINES    = 240,
    parameter int ADDR_W     = 17,
    parameter int RD_LATENCY = 2,
    parameter int LINE_GAP   = 4,
    localparam int COL_W     = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1,
    localparam int ROW_W     = (V_LINES > 1) ? $clog2(V_LINES) : 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              continuous_i,
    input  logic              stop_i,
    input  logic              pause_i,
    output logic [ADDR_W-1:0] rdaddress_o,
    output logic              busy_o,
    output logic              pix_valid_o,
    output logic              pix_sof_o,
    output logic              pix_eol_o,
    output logic              pix_eof_o,
    output logic [COL_W-1:0]  pix_col_o,
    output logic [ROW_W-1:0]  pix_row_o,
    output logic              frame_done_o
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RUN    = 3'd1;
    localparam logic [2:0] ST_GAP    = 3'd2;
    localparam logic [2:0] ST_PAUSED = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;

    // One counter serves both the line gap and the drain interval.
    localparam int CNT_MAX = (LINE_GAP > RD_LATENCY) ? LINE_GAP : RD_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef struct packed {
        logic             valid;
        logic             sof;
        logic             eol;
        logic             eof;
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
    } tag_t;

    logic [2:0]        state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stop_pend_q, stop_pend_d;
    logic              busy_q;
    tag_t              pipe_q [RD_LATENCY];

    logic              issue_s;
    logic              line_end_s;
    logic              last_row_s;
    logic [ADDR_W-1:0] resume_addr_s;
    tag_t              tag_s;
    tag_t              out_s;

    assign line_end_s = (col_q == COL_W'(H_PIXELS - 1));
    assign last_row_s = (row_q == ROW_W'(V_LINES - 1));

    // When issue resumes after a gap or pause, row 0 can only mean the frame
    // just wrapped, so the address restarts at 0; otherwise it continues.
    assign resume_addr_s = (row_q == {ROW_W{1'b0}}) ? {ADDR_W{1'b0}} : (addr_q + 1'b1);

    // Next-state logic for the sequencer FSM, raster counters and address.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        issue_s     = 1'b0;
        if ((state_q != ST_IDLE) && stop_i) begin
            stop_pend_d = 1'b1;
        end else begin
            stop_pend_d = stop_pend_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d     = ST_RUN;
                    col_d       = {COL_W{1'b0}};
                    row_d       = {ROW_W{1'b0}};
                    addr_d      = {ADDR_W{1'b0}};
                    stop_pend_d = 1'b0;
                end else begin
                    addr_d      = {ADDR_W{1'b0}};
                end
            end
            ST_RUN: begin
                issue_s = 1'b1;
                if (!line_end_s) begin
                    col_d  = col_q + 1'b1;
                    addr_d = addr_q + 1'b1;
                end else begin
                    col_d = {COL_W{1'b0}};
                    if (!last_row_s) begin
                        row_d = row_q + 1'b1;
                        if (LINE_GAP > 0) begin
                            state_d = ST_GAP;
                            cnt_d   = {CNT_W{1'b0}};
                        end else if (pause_i) begin
                            state_d = ST_PAUSED;
                        end else begin
                            addr_d  = addr_q + 1'b1;
                        end
                    end else if (continuous_i && !stop_pend_q && !stop_i) begin
                        // Continuous restart; the address holds until issue resumes.
                        row_d = {ROW_W{1'b0}};
                        if (LINE_GAP > 0) begin
                            state_d = ST_GAP;
                            cnt_d   = {CNT_W{1'b0}};
                        end else if (pause_i) begin
                            state_d = ST_PAUSED;
                        end else begin
                            addr_d  = {ADDR_W{1'b0}};
                        end
                    end else begin
                        state_d = ST_DRAIN;
                        cnt_d   = {CNT_W{1'b0}};
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(LINE_GAP - 1)) begin
                    if (pause_i) begin
                        state_d = ST_PAUSED;
                    end else begin
                        state_d = ST_RUN;
                        addr_d  = resume_addr_s;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PAUSED: begin
                if (!pause_i) begin
                    state_d = ST_RUN;
                    addr_d  = resume_addr_s;
                end else begin
                    state_d = ST_PAUSED;
                end
            end
            ST_DRAIN: begin
                // Stay busy until the last issued beat has left the pipeline.
                if (cnt_q == CNT_W'(RD_LATENCY - 1)) begin
                    state_d = ST_IDLE;
                    addr_d  = {ADDR_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Tag for the address presented this cycle; zero on non-issue cycles.
    always_comb begin
        tag_s       = '0;
        tag_s.valid = issue_s;
        if (issue_s) begin
            tag_s.sof = (col_q == {COL_W{1'b0}}) && (row_q == {ROW_W{1'b0}});
            tag_s.eol = line_end_s;
            tag_s.eof = line_end_s && last_row_s;
            tag_s.col = col_q;
            tag_s.row = row_q;
        end else begin
            tag_s.sof = 1'b0;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            col_q       <= {COL_W{1'b0}};
            row_q       <= {ROW_W{1'b0}};
            addr_q      <= {ADDR_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            stop_pend_q <= stop_pend_d;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    // Tag shift register matching the memory read latency.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= tag_s;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign out_s        = pipe_q[RD_LATENCY-1];
    assign rdaddress_o  = addr_q;
    assign busy_o       = busy_q;
    assign pix_valid_o  = out_s.valid;
    assign pix_sof_o    = out_s.sof;
    assign pix_eol_o    = out_s.eol;
    assign pix_eof_o    = out_s.eof;
    assign pix_col_o    = out_s.col;
    assign pix_row_o    = out_s.row;
    assign frame_done_o = out_s.eof;

endmodule

// File: tb/tb_frame_read_sequencer.sv
// -----------------------------------------------------------------------------
// tb_frame_read_sequencer
//
// Self-checking bench for frame_read_sequencer (4x3 frame, read latency 2,
// 2-cycle line gap). A reference model tracks the linear pixel index being
// read and schedules each expected output beat RD_LATENCY cycles after its
// address is presented; a negedge monitor compares the full output trace.
// Scenario tasks add targeted checks of the timing landmarks.
// -----------------------------------------------------------------------------
module tb_frame_read_sequencer;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int AW = 4;
    localparam int L  = 2;
    localparam int G  = 2;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_GAP    = 2;
    localparam int M_PAUSED = 3;
    localparam int M_DRAIN  = 4;

    logic          clk;
    logic          reset, start, continuous, stop, pause;
    logic [AW-1:0] rdaddress;
    logic          busy, pix_valid, pix_sof, pix_eol, pix_eof, frame_done;
    logic [1:0]    pix_col;
    logic [1:0]    pix_row;

    int checks, errors;
    int cyc;
    bit mon_en;
    int fd_cnt, sof_cnt, last_sof_cyc, last_eof_cyc;

    int m_mode, m_pix, m_addr, m_cnt;
    bit m_stop;
    int beat_at [int];

    frame_read_sequencer #(
        .H_PIXELS(H), .V_LINES(V), .ADDR_W(AW), .RD_LATENCY(L), .LINE_GAP(G)
    ) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .continuous_i(continuous),
        .stop_i(stop), .pause_i(pause), .rdaddress_o(rdaddress), .busy_o(busy),
        .pix_valid_o(pix_valid), .pix_sof_o(pix_sof), .pix_eol_o(pix_eol),
        .pix_eof_o(pix_eof), .pix_col_o(pix_col), .pix_row_o(pix_row),
        .frame_done_o(frame_done)
    );

    always #5 clk = ~clk;

    // After a line is issued: gap, pause or straight on to the next pixel.
    task automatic next_line();
        if (G > 0) begin
            m_mode = M_GAP;
            m_cnt  = G;
        end else if (pause) begin
            m_mode = M_PAUSED;
        end else begin
            m_mode = M_RUN;
            m_addr = m_pix;
        end
    endtask

    // Reference model: from the inputs of cycle cyc, derive cycle cyc+1.
    task automatic model_step();
        if (reset) begin
            m_mode = M_IDLE;
            m_addr = 0;
            m_stop = 0;
            beat_at.delete();
        end else begin
            if (m_mode != M_IDLE && stop) m_stop = 1;
            case (m_mode)
                M_IDLE: if (start) begin
                    m_mode = M_RUN; m_pix = 0; m_addr = 0; m_stop = 0;
                end
                M_RUN: begin
                    beat_at[cyc + L] = m_pix;
                    if (m_pix == H*V - 1) begin
                        if (continuous && !m_stop) begin
                            m_pix = 0;
                            next_line();
                        end else begin
                            m_mode = M_DRAIN;
                            m_cnt  = L;
                        end
                    end else if ((m_pix + 1) % H == 0) begin
                        m_pix = m_pix + 1;
                        next_line();
                    end else begin
                        m_pix  = m_pix + 1;
                        m_addr = m_pix;
                    end
                end
                M_GAP: begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) begin
                        if (pause) m_mode = M_PAUSED;
                        else begin m_mode = M_RUN; m_addr = m_pix; end
                    end
                end
                M_PAUSED: if (!pause) begin
                    m_mode = M_RUN; m_addr = m_pix;
                end
                M_DRAIN: begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) begin m_mode = M_IDLE; m_addr = 0; end
                end
                default: m_mode = M_IDLE;
            endcase
        end
        cyc = cyc + 1;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound, output int fell, output bit ok);
        ok = 0;
        fell = -1;
        for (int i = 0; i < bound; i++) begin
            if (busy === 1'b0) begin
                ok = 1;
                fell = cyc;
                return;
            end
            cycle();
        end
    endtask

    // Full-trace comparison of every DUT output against the model.
    always @(negedge clk) begin : monitor
        int p;
        logic [8:0] exp_b, got_b;
        if (mon_en) begin
            exp_b = 9'd0;
            if (beat_at.exists(cyc)) begin
                p = beat_at[cyc];
                exp_b = {1'b1, p == 0, (p % H) == H - 1, p == H*V - 1, p == H*V - 1,
                         2'(p % H), 2'(p / H)};
            end
            got_b = {pix_valid, pix_sof, pix_eol, pix_eof, frame_done, pix_col, pix_row};
            checks++;
            if (rdaddress !== AW'(m_addr)) begin
                errors++;
                $display("FAIL rdaddress cyc=%0d got %0d want %0d", cyc, rdaddress, m_addr);
            end
            checks++;
            if (busy !== (m_mode != M_IDLE)) begin
                errors++;
                $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, m_mode != M_IDLE);
            end
            checks++;
            if (got_b !== exp_b) begin
                errors++;
                $display("FAIL beat cyc=%0d got %b want %b (v,sof,eol,eof,done,col,row)",
                         cyc, got_b, exp_b);
            end
            if (pix_sof === 1'b1) begin sof_cnt++; last_sof_cyc = cyc; end
            if (frame_done === 1'b1) begin fd_cnt++; last_eof_cyc = cyc; end
        end
    end

    task automatic test_reset();
        checks++;
        if ({rdaddress, busy, pix_valid, pix_sof, pix_eol, pix_eof, frame_done, pix_col, pix_row} !== 15'd0) begin
            errors++;
            $display("FAIL reset_state got addr=%0d busy=%b valid=%b want all zero", rdaddress, busy, pix_valid);
        end
        reset  = 1'b0;
        mon_en = 1'b1;
        cycle();
    endtask

    task automatic test_single_frame();
        int t0, fd0, fell, eof_want;
        bit ok;
        fd0 = fd_cnt;
        continuous = 1'b0;
        start = 1'b1; t0 = cyc; cycle(); start = 1'b0;
        checks++;
        if (rdaddress !== 4'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_first_addr got %0d/%b want 0/1", rdaddress, busy);
        end
        wait_idle(200, fell, ok);
        eof_want = t0 + H*V + (V-1)*G + L;
        checks++;
        if (!ok) begin errors++; $display("FAIL single_timeout got busy want idle"); end
        checks++;
        if (last_sof_cyc !== t0 + 1 + L) begin
            errors++; $display("FAIL single_sof_cycle got %0d want %0d", last_sof_cyc - t0, 1 + L);
        end
        checks++;
        if (last_eof_cyc !== eof_want) begin
            errors++; $display("FAIL single_eof_cycle got %0d want %0d", last_eof_cyc - t0, eof_want - t0);
        end
        checks++;
        if (fd_cnt - fd0 !== 1) begin
            errors++; $display("FAIL single_done_count got %0d want 1", fd_cnt - fd0);
        end
        checks++;
        if (fell !== eof_want + 1) begin
            errors++; $display("FAIL single_busy_fall got %0d want %0d", fell - t0, eof_want + 1 - t0);
        end
    endtask

    task automatic test_continuous_stop();
        int fd0, sof0, fell, n;
        bit ok;
        fd0 = fd_cnt; sof0 = sof_cnt;
        continuous = 1'b1;
        start = 1'b1; cycle(); start = 1'b0;
        n = 0;
        while (sof_cnt < sof0 + 2 && n < 200) begin cycle(); n++; end
        checks++;
        if (sof_cnt < sof0 + 2) begin errors++; $display("FAIL cont_second_sof got %0d want 2", sof_cnt - sof0); end
        repeat (3) cycle();
        stop = 1'b1; cycle(); stop = 1'b0;
        wait_idle(200, fell, ok);
        continuous = 1'b0;
        repeat (5) cycle();
        checks++;
        if (!ok) begin errors++; $display("FAIL cont_timeout got busy want idle"); end
        checks++;
        if (fd_cnt - fd0 !== 2) begin errors++; $display("FAIL cont_done_count got %0d want 2", fd_cnt - fd0); end
        checks++;
        if (sof_cnt - sof0 !== 2) begin errors++; $display("FAIL cont_sof_count got %0d want 2", sof_cnt - sof0); end
    endtask

    task automatic test_pause();
        int fd0, n, fell;
        bit ok;
        fd0 = fd_cnt;
        continuous = 1'b0;
        start = 1'b1; cycle(); start = 1'b0;
        n = 0;
        while (rdaddress !== 4'd5 && n < 50) begin cycle(); n++; end
        checks++;
        if (rdaddress !== 4'd5) begin errors++; $display("FAIL pause_reach5 got %0d want 5", rdaddress); end
        pause = 1'b1;
        repeat (10) cycle();
        checks++;
        if (rdaddress !== 4'd7 || busy !== 1'b1 || pix_valid !== 1'b0) begin
            errors++; $display("FAIL pause_hold got addr=%0d valid=%b want addr=7 valid=0", rdaddress, pix_valid);
        end
        pause = 1'b0; cycle();
        checks++;
        if (rdaddress !== 4'd8) begin errors++; $display("FAIL pause_resume got %0d want 8", rdaddress); end
        wait_idle(200, fell, ok);
        checks++;
        if (!ok || fd_cnt - fd0 !== 1) begin
            errors++; $display("FAIL pause_done got %0d want 1", fd_cnt - fd0);
        end
    endtask

    task automatic test_reset_midframe();
        int n, t0, fell;
        bit ok;
        start = 1'b1; cycle(); start = 1'b0;
        n = 0;
        while (rdaddress !== 4'd5 && n < 50) begin cycle(); n++; end
        reset = 1'b1; cycle(); reset = 1'b0;
        checks++;
        if ({rdaddress, busy, pix_valid, pix_sof, pix_eol, pix_eof, frame_done, pix_col, pix_row} !== 15'd0) begin
            errors++; $display("FAIL midreset_state got addr=%0d busy=%b valid=%b want all zero", rdaddress, busy, pix_valid);
        end
        repeat (4) cycle();
        start = 1'b1; t0 = cyc; cycle(); start = 1'b0;
        wait_idle(200, fell, ok);
        checks++;
        if (!ok || last_sof_cyc !== t0 + 1 + L) begin
            errors++; $display("FAIL midreset_restart_sof got %0d want %0d", last_sof_cyc - t0, 1 + L);
        end
    endtask

    task automatic test_ignored_controls();
        int fd0, n, fell;
        bit ok;
        stop = 1'b1; cycle(); stop = 1'b0;
        fd0 = fd_cnt;
        continuous = 1'b1;
        start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
        n = 0;
        while (fd_cnt < fd0 + 2 && n < 300) begin
            start = (n % 7 == 3);
            cycle(); n++;
        end
        start = 1'b0;
        checks++;
        if (fd_cnt - fd0 !== 2) begin errors++; $display("FAIL ignored_cont got %0d want 2", fd_cnt - fd0); end
        stop = 1'b1; cycle(); stop = 1'b0;
        continuous = 1'b0;
        wait_idle(200, fell, ok);
        checks++;
        if (!ok || fd_cnt - fd0 !== 3) begin
            errors++; $display("FAIL ignored_final_count got %0d want 3", fd_cnt - fd0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2500; i++) begin
            start = ($urandom_range(0, 19) == 0);
            stop  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) == 0) pause = ~pause;
            if ($urandom_range(0, 99) == 0) continuous = ~continuous;
            reset = ($urandom_range(0, 399) == 0);
            cycle();
        end
        start = 1'b0; stop = 1'b0; pause = 1'b0; continuous = 1'b0; reset = 1'b0;
        repeat (60) cycle();
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; start = 1'b0; continuous = 1'b0; stop = 1'b0; pause = 1'b0;
        checks = 0; errors = 0; cyc = 0; mon_en = 1'b0;
        fd_cnt = 0; sof_cnt = 0; last_sof_cyc = -1; last_eof_cyc = -1;
        m_mode = M_IDLE; m_pix = 0; m_addr = 0; m_cnt = 0; m_stop = 0;
        cycle();
        cycle();
        test_reset();
        test_single_frame();
        test_continuous_stop();
        test_pause();
        test_reset_midframe();
        test_ignored_controls();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_read_sequencer.md
Name: frame_read_sequencer

Overview:
Read-side controller for the frame memory that feeds the image processor. It generates the raster-order `rdaddress` sequence into `stream_mif`, with optional inter-line gaps, line-granular pause, and single-shot or continuous frame modes. It also produces a valid/marker pipeline aligned to the memory read latency, so the image processor sees `rddata` with matching `pix_valid`, `sof`, `eol` and `eof`. It sits in the `clk_25_vga` domain, between the top-level control and `stream_mif`/image processor.

Parameters:
H_PIXELS, 320, pixels per line
V_LINES, 240, lines per frame
ADDR_W, 17, rdaddress width; must satisfy 2^ADDR_W >= H_PIXELS*V_LINES
RD_LATENCY, 2, cycles from rdaddress change to matching data at memory output (>=1)
LINE_GAP, 4, idle cycles inserted after every line, including after the last line in continuous mode (0 = none)

Ports:
clk  in  1  single clock (clk_25_vga domain)
reset  in  1  synchronous, active-high
start  in  1  pulse; begins a frame when idle
continuous  in  1  sampled at each frame end; 1 = start the next frame automatically
stop  in  1  pulse; finish the current frame, then return to idle; sticky until honoured
pause  in  1  level; sampled at each line end; holds issue while high
rdaddress  out  ADDR_W  read address to stream_mif
busy  out  1  high in any state except IDLE
pix_valid  out  1  rddata valid this cycle
pix_sof  out  1  with pix_valid: first pixel of frame
pix_eol  out  1  with pix_valid: last pixel of line
pix_eof  out  1  with pix_valid: last pixel of frame
pix_col  out  $clog2(H_PIXELS)  column of current valid pixel
pix_row  out  $clog2(V_LINES)  row of current valid pixel
frame_done  out  1  one-cycle pulse, coincident with the pix_eof beat

Behaviour:
- Reset: state IDLE. All of the following are 0: outputs, col/row counters, stop_pending, and every stage of the RD_LATENCY valid/marker pipeline. A reset mid-frame discards in-flight beats; no marker may emerge afterwards.
- States: IDLE, RUN, GAP, PAUSED, DRAIN.
- IDLE:
  - rdaddress=0, busy=0.
  - start=1 -> RUN next cycle with col=row=0; stop_pending cleared.
  - stop in IDLE is ignored.
- RUN: each cycle, issue rdaddress = row*H_PIXELS + col. The address is kept as an incrementing counter; no multiplier. Then col++.
  - At col==H_PIXELS-1, not last row:
    - col<=0, row++.
    - Next state: GAP if LINE_GAP>0; else PAUSED if pause=1; else RUN.
  - At col==H_PIXELS-1, row==V_LINES-1 (frame end):
    - If continuous=1 and no stop_pending: row<=0, address counter wraps to 0, go to GAP (or RUN if LINE_GAP=0).
    - Otherwise: go to DRAIN.
- GAP:
  - Counts LINE_GAP cycles, no issue; rdaddress holds its last value.
  - On expiry: PAUSED if pause=1, else RUN.
- PAUSED: no issue; rdaddress held. pause=0 -> RUN next cycle.
- DRAIN:
  - Counts RD_LATENCY cycles, no issue.
  - Then IDLE; rdaddress returns to 0.
- Issue tagging: each issued address carries issue=1 plus sof/eol/eof/col/row tags into a RD_LATENCY-deep shift register.
  - Outputs appear exactly RD_LATENCY cycles after rdaddress presents the issued address.
  - Non-issue cycles insert a bubble, which produces pix_valid=0.
  - Marker/col/row outputs are 0 whenever pix_valid=0.
- Latency: start sampled at cycle 0 -> rdaddress=0 at cycle 1 -> pix_valid/pix_sof at cycle 1+RD_LATENCY.
- stop: sets stop_pending on any cycle while busy. It never truncates a frame; it only suppresses the continuous restart at the next frame end.
- start while busy: ignored.
- Simultaneous start and stop in IDLE: start wins; stop is ignored.
- pause is sampled only at line end and on GAP expiry. Mid-line pause changes have no effect until the line completes.
- frame_done: asserted on the same cycle as the pix_eof beat, in both single and continuous mode.
- busy: remains 1 through DRAIN, until the final beat has emerged.

Test Plan:
- H=4,V=3,LINE_GAP=0,RD_LATENCY=2, start pulse at cycle 0, continuous=0 -> rdaddress 0..11 on cycles 1..12; pix_valid on cycles 3..14; sof at cycle 3; eol at cycles 6,10,14; eof+frame_done at cycle 14; busy falls at cycle 15.
- Same config with LINE_GAP=2 -> 2-cycle valid bubbles after each eol; addresses remain contiguous 0..11; eof at cycle 18.
- continuous=1 for 2 frames, then stop pulse mid-frame 2 -> frame 2 completes fully (addresses wrap 11->0 after the gap); no third sof; exactly two frame_done pulses.
- pause raised mid-line 1 -> line 1 completes; issue halts at the line boundary with rdaddress held at 7; pause drop -> rdaddress 8 next cycle; pix_row/pix_col sequence unbroken.
- reset asserted 1 cycle after rdaddress=5 issues -> next cycle all outputs 0, state IDLE; no pix_valid for in-flight addresses 4/5; a fresh start restarts at address 0 with sof.
- start pulses while busy, and stop while idle -> no effect: address sequence and frame_done count unchanged.
